// File: rtl/hbc_mcp_bus_if.sv
// Host bus interface for the math co-processor: synchronises the async host strobes, holds the
// operands, launches the multiply and serves result/status. Option macro: HBC_MCP_AUTOSTART_EN.
module hbc_mcp_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic [2:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_start,
    input  logic [31:0] res,
    input  logic        res_valid
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [7:0] WdogLoad = 8'(TIMEOUT);

    logic       wr_s1_q, wr_s2_q, wr_d_q;
    logic       rd_s1_q, rd_s2_q, rd_d_q;
    logic [2:0] addr_q;
    logic [7:0] data_q;

    logic [7:0] ah_q, al_q, bh_q, bl_q;
    logic [31:0] res_q;
    logic       overrun_q, timeout_q;
    logic [7:0] wdog_q;
    state_e     state_q;

    logic wr_fall, rd_rise, reg_wr, start_req, stat_clr, busy;

    // Strobes idle high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_s1_q <= 1'b1;
            wr_s2_q <= 1'b1;
            wr_d_q  <= 1'b1;
            rd_s1_q <= 1'b1;
            rd_s2_q <= 1'b1;
            rd_d_q  <= 1'b1;
            addr_q  <= 3'd0;
            data_q  <= 8'h00;
        end else begin
            wr_s1_q <= wr_n;
            wr_s2_q <= wr_s1_q;
            wr_d_q  <= wr_s2_q;
            rd_s1_q <= rd_n;
            rd_s2_q <= rd_s1_q;
            rd_d_q  <= rd_s2_q;
            addr_q  <= addr;
            data_q  <= data_in;
        end
    end

    assign wr_fall  = wr_d_q & ~wr_s2_q;
    assign rd_rise  = ~rd_d_q & rd_s2_q;
    assign reg_wr   = wr_fall && ((addr_q <= 3'd3) || (addr_q == 3'd7));
    assign stat_clr = rd_rise && (addr_q == 3'd4);
    assign busy     = (state_q == StBusy);

    always_comb begin
        start_req = wr_fall && (addr_q == 3'd7) && data_q[0];
`ifdef HBC_MCP_AUTOSTART_EN
        if (wr_fall && (addr_q == 3'd3)) begin
            start_req = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ah_q <= 8'h00;
            al_q <= 8'h00;
            bh_q <= 8'h00;
            bl_q <= 8'h00;
        end else if (reg_wr && !busy && !addr_q[2]) begin
            case (addr_q[1:0])
                2'd0: ah_q <= data_q;
                2'd1: al_q <= data_q;
                2'd2: bh_q <= data_q;
                2'd3: bl_q <= data_q;
                default: ;
            endcase
        end
    end

    // Flag sets are placed after the clear so a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wdog_q    <= 8'd0;
            op_start  <= 1'b0;
            res_q     <= 32'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            op_start <= 1'b0;
            if (stat_clr) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (reg_wr && busy) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start_req) begin
                        op_start <= 1'b1;
                        wdog_q   <= WdogLoad;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (res_valid) begin
                        res_q   <= res;
                        wdog_q  <= 8'd0;
                        state_q <= StIdle;
                    end else if (wdog_q <= 8'd1) begin
                        timeout_q <= 1'b1;
                        wdog_q    <= 8'd0;
                        state_q   <= StIdle;
                    end else begin
                        wdog_q <= wdog_q - 8'd1;
                    end
                end
            endcase
        end
    end

    assign op_a    = {ah_q, al_q};
    assign op_b    = {bh_q, bl_q};
    assign data_oe = !rd_n && !rst;

    always_comb begin
        data_out = 8'h00;
        if (!rst) begin
            case (addr)
                3'd0:    data_out = res_q[31:24];
                3'd1:    data_out = res_q[23:16];
                3'd2:    data_out = res_q[15:8];
                3'd3:    data_out = res_q[7:0];
                3'd4:    data_out = {5'b00000, timeout_q, overrun_q, busy};
                default: data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_hbc_mcp_bus_if.sv
// Self-checking bench for hbc_mcp_bus_if: directed host-bus scenarios plus random register
// traffic, checked against a transaction-level model of the register file and status flags.
module tb_hbc_mcp_bus_if;

    localparam int unsigned TIMEOUT = 10;
`ifdef HBC_MCP_AUTOSTART_EN
    localparam bit AutoStart = 1'b1;
`else
    localparam bit AutoStart = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_n = 1'b1;
    logic        rd_n = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [15:0] op_a, op_b;
    logic        op_start;
    logic [31:0] res = 32'd0;
    logic        res_valid = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    hbc_mcp_bus_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_start  (op_start),
        .res       (res),
        .res_valid (res_valid)
    );

    always #5 clk = ~clk;

    // Math-stage stand-in: answers each op_start after 'lat' cycles (lat = 0: never).
    int unsigned cyc = 0;
    int unsigned lat = 5;
    int unsigned start_cyc = 0;
    int unsigned spur_cyc = 32'hFFFF_FFFF;
    int unsigned n_start = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (op_start) begin
            n_start   = n_start + 1;
            pend      = (lat != 0);
            start_cyc = cyc;
            pend_res  = $signed(op_a) * $signed(op_b);
        end
        if (pend && (cyc == start_cyc + lat - 1)) begin
            res_valid = 1'b1;
            res       = pend_res;
            pend      = 1'b0;
        end else if (cyc == spur_cyc) begin
            res_valid = 1'b1;
            res       = $urandom;
        end else begin
            res_valid = 1'b0;
            res       = $urandom;
        end
    end

    // Transaction-level model
    logic [15:0] m_a = 16'd0, m_b = 16'd0;
    logic [31:0] m_res = 32'd0, m_prod = 32'd0;
    bit          m_busy = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
    int unsigned m_nstart = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {5'b00000, m_to, m_ovr, m_busy};
    endfunction

    function automatic logic [7:0] m_byte(input logic [2:0] a);
        case (a)
            3'd0:    return m_res[31:24];
            3'd1:    return m_res[23:16];
            3'd2:    return m_res[15:8];
            3'd3:    return m_res[7:0];
            3'd4:    return m_status();
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [7:0] d, output bit started);
        started = 1'b0;
        if (a <= 3'd3 || a == 3'd7) begin
            if (m_busy) begin
                m_ovr = 1'b1;
            end else begin
                case (a)
                    3'd0: m_a[15:8] = d;
                    3'd1: m_a[7:0]  = d;
                    3'd2: m_b[15:8] = d;
                    3'd3: begin m_b[7:0] = d; started = AutoStart; end
                    default: started = d[0];
                endcase
            end
        end
        if (started) begin
            m_busy = 1'b1;
            m_nstart++;
            m_prod = $signed({{16{m_a[15]}}, m_a}) * $signed({{16{m_b[15]}}, m_b});
        end
    endtask

    task automatic m_finish();
        if (lat >= 1 && lat <= TIMEOUT) m_res = m_prod;
        else m_to = 1'b1;
        m_busy = 1'b0;
    endtask

    task automatic m_reset();
        m_a = 16'd0; m_b = 16'd0; m_res = 32'd0;
        m_busy = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
    endtask

    // Called at a negedge; strobe low 4 cycles after a 4-cycle high gap.
    task automatic host_write(input logic [2:0] a, input logic [7:0] d, output bit started);
        logic [31:0] pre;
        repeat (4) @(negedge clk);
        pre = {m_a, m_b};
        m_write(a, d, started);
        addr = a; data_in = d; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("ops_before_commit", {op_a, op_b}, pre);
        @(negedge clk);
        chk("ops_after_commit", {op_a, op_b}, {m_a, m_b});
        chk("op_start_pulse", {31'd0, op_start}, {31'd0, started});
        @(negedge clk);
        chk("op_start_one_cycle", {31'd0, op_start}, 32'd0);
        wr_n = 1'b1;
    endtask

    task automatic host_read(input logic [2:0] a);
        repeat (4) @(negedge clk);
        addr = a; rd_n = 1'b0;
        #1;
        chk("data_oe_read", {31'd0, data_oe}, 32'd1);
        repeat (3) @(negedge clk);
        chk($sformatf("read_addr%0d", a), {24'd0, data_out}, {24'd0, m_byte(a)});
        if (a == 3'd4) begin m_ovr = 1'b0; m_to = 1'b0; end
        @(negedge clk);
        rd_n = 1'b1;
    endtask

    // Status through the combinational mux without a read strobe, so nothing clears.
    task automatic peek_status(input string tag);
        addr = 3'd4;
        #1;
        chk(tag, {24'd0, data_out}, {24'd0, m_status()});
    endtask

    task automatic wait_done();
        repeat (TIMEOUT + 3) @(negedge clk);
        m_finish();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] a;
        logic [7:0] d;
        bit s;

        // Reset with the read strobe asserted
        rst = 1'b1; rd_n = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            addr = 3'(i);
            #1;
            chk("data_oe_in_reset", {31'd0, data_oe}, 32'd0);
            chk("data_out_in_reset", {24'd0, data_out}, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("op_start_in_reset", {31'd0, op_start}, 32'd0);
        chk("ops_in_reset", {op_a, op_b}, 32'd0);
        rd_n = 1'b1; rst = 1'b0;
        for (int i = 0; i <= 4; i++) host_read(3'(i));

        // A = 3, B = -2, product -6 after 5 cycles
        lat = 5;
        host_write(3'd0, 8'h00, s);
        host_write(3'd1, 8'h03, s);
        host_write(3'd2, 8'hFF, s);
        host_write(3'd3, 8'hFE, s);
        if (!s) host_write(3'd7, 8'h01, s);
        peek_status("status_busy_ab");
        wait_done();
        chk("start_count_ab", n_start, m_nstart);
        for (int i = 0; i <= 3; i++) host_read(3'(i));
        host_read(3'd4);

        // Spurious res_valid while idle
        spur_cyc = cyc + 1;
        repeat (3) @(negedge clk);
        host_read(3'd3);

        // Operand write while busy; result lands on the watchdog-expiry edge
        lat = TIMEOUT;
        host_write(3'd7, 8'h01, s);
        host_write(3'd0, 8'h55, s);
        peek_status("status_overrun_busy");
        chk("ah_kept", {24'd0, op_a[15:8]}, {24'd0, m_a[15:8]});
        wait_done();
        host_read(3'd4);
        host_read(3'd4);

        // Watchdog timeout: busy up to the 10th cycle, idle with timeout after
        lat = 0;
        host_write(3'd7, 8'h01, s);
        repeat (8) @(negedge clk);
        peek_status("status_before_expiry");
        @(negedge clk);
        m_finish();
        peek_status("status_after_expiry");
        for (int i = 0; i <= 3; i++) host_read(3'(i));
        host_read(3'd4);
        host_read(3'd4);

        // res_valid exactly on the expiry cycle with fresh operands
        lat = TIMEOUT;
        host_write(3'd0, 8'h12, s);
        host_write(3'd1, 8'h34, s);
        host_write(3'd2, 8'h80, s);
        host_write(3'd3, 8'h07, s);
        if (!s) host_write(3'd7, 8'h01, s);
        wait_done();
        host_read(3'd4);
        for (int i = 0; i <= 3; i++) host_read(3'(i));
        chk("start_count_expiry", n_start, m_nstart);

        // Reset during busy; the late res_valid must be ignored
        lat = 6;
        host_write(3'd7, 8'h01, s);
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("start_count_after_reset", n_start, m_nstart);
        chk("ops_after_reset", {op_a, op_b}, {m_a, m_b});
        for (int i = 0; i <= 4; i++) host_read(3'(i));

        // Random register traffic
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 3'd7 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
                lat = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT);
                host_write(a, d, s);
                if (s) begin
                    wait_done();
                    chk("start_count_rand", n_start, m_nstart);
                end
            end else if (kind <= 4) begin
                host_read(3'($urandom_range(0, 7)));
            end else begin
                spur_cyc = cyc + 1;
                repeat (3) @(negedge clk);
            end
        end
        for (int i = 0; i <= 4; i++) host_read(3'(i));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hbc_mcp_bus_if.md
# hbc_mcp_bus_if

Host-side bus interface for the homebrew math co-processor. Brings the asynchronous 8-bit parallel host bus (WRn/RDn strobes, 3-bit address, 8-bit data) into the `clk` domain. Holds the 16-bit operand registers and issues a start pulse to the downstream multiply stage. Latches the 32-bit result and serves it back to the host, together with a status register and a timeout watchdog.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for `res_valid` after `op_start` before aborting (1..255).

Ports:
- clk  in  1  system clock, board 27 MHz.
- rst  in  1  synchronous reset, active-high.
- wr_n  in  1  host write strobe, async, active-low.
- rd_n  in  1  host read strobe, async, active-low.
- addr  in  3  host register address, async.
- data_in  in  8  host write data, async.
- data_out  out  8  host read data; top level drives pad when `data_oe`.
- data_oe  out  1  pad output enable.
- op_a  out  16  operand A = {Ah, Al}, signed.
- op_b  out  16  operand B = {Bh, Bl}, signed.
- op_start  out  1  one-cycle start pulse to the math stage.
- res  in  32  signed product from the math stage.
- res_valid  in  1  one-cycle result-valid pulse from the math stage.

## Operation
- **Synchronisation**
  - `wr_n` and `rd_n` each pass through a 2-FF synchroniser plus an edge-detect register.
  - `addr` and `data_in` are registered once every cycle.
- **Write commit**
  - Occurs on the synchronised falling edge of `wr_n`.
  - `addr` 0 writes Ah, 1 writes Al, 2 writes Bh, 3 writes Bl.
  - `addr` 7 is the command register; writing it with bit0 = 1 requests a start.
  - `addr` 4–6 are ignored on write.
- **Read map**
  - `addr` 0–3 return result bytes Y[31:24], Y[23:16], Y[15:8], Y[7:0].
  - `addr` 4 returns status: bit0 busy, bit1 overrun, bit2 timeout, bits 7:3 = 0.
  - `addr` 5–7 return 0x00.
- **Read path**
  - `data_out` is a combinational mux on raw `addr`.
  - `data_oe` = !`rd_n` && !`rst`.
  - On the synchronised rising edge of `rd_n` with registered `addr` = 4, overrun and timeout clear.
- **FSM**
  - IDLE: a start request issues `op_start`, loads the watchdog with TIMEOUT, and moves to BUSY.
  - BUSY, `res_valid` = 1: latch `res` into the result register and return to IDLE.
  - BUSY, watchdog reaches 0: set timeout, leave the result unchanged, return to IDLE.
- **Boundary rules**
  - Any operand or command write while BUSY is dropped, registers stay unchanged, and overrun is set.
  - `res_valid` in IDLE is ignored.
  - `res_valid` and watchdog expiry in the same cycle: the result wins and timeout is not set.
  - A status clear and a new flag set in the same cycle: the set wins.
  - Reads during BUSY return the previous result.
- **Reset**
  - All operand, result and status registers go to 0.
  - FSM goes to IDLE and the watchdog to 0.
  - `op_start` = 0, `data_oe` = 0, `op_a` = `op_b` = 0, `data_out` = 0x00.
  - Reset mid-operation aborts BUSY silently; a later `res_valid` is ignored.

## Timing
- **Write strobe**
  - Commit happens on the 3rd `clk` edge after `wr_n` falls; `op_a`/`op_b` update on that edge.
  - `op_start` is high for exactly one cycle, on the cycle after the commit.
- **Host bus requirements**
  - Strobe low width ≥ 4 `clk` periods.
  - High time between strobes ≥ 4 `clk` periods.
  - `addr`/`data_in` stable from the strobe falling edge until its rising edge.
- **Busy flag**
  - Status busy reads 1 from the cycle after `op_start` until the edge on which `res_valid` is sampled.
  - Result bytes are readable the cycle after that edge.
- **Watchdog**
  - Expires TIMEOUT cycles after `op_start` if no `res_valid` arrives.
- **Read path**
  - Combinational from the pads: `data_out` valid one mux delay after `addr`/`rd_n`.

## Configuration
- Macro: `HBC_MCP_AUTOSTART_EN`.
- Defined: a committed write to `addr` 3 (Bl) also requests a start. A host writes Ah, Al, Bh, Bl and the multiply launches; `addr` 7 still works.
- Undefined: only a write of bit0 = 1 to `addr` 7 starts an operation. Writing Bl only updates the register.

## Test plan
- Reset, then read `addr` 0–4: all 0x00; `data_oe` = 0 while `rst` is high, even with `rd_n` low.
- Write A = 0x0003, B = 0xFFFE, then start, with the model returning −6 after 5 cycles.
  - Start is via `addr` 3 with the macro defined, via `addr` 7 = 0x01 without.
  - `op_start` pulses exactly once; status reads 0x01 during the wait.
  - `addr` 0–3 then read 0xFF, 0xFF, 0xFF, 0xFA.
- While BUSY, write 0x55 to `addr` 0: Ah unchanged, status = 0x03; after completion and one status read, status = 0x00.
- Start with the model never asserting `res_valid` and TIMEOUT = 10.
  - Returns to IDLE after 10 cycles; status = 0x04; result keeps its prior value.
- `res_valid` on the exact watchdog-expiry cycle: result latched, status = 0x00.
- Assert `rst` during BUSY, then pulse `res_valid`: result stays 0; no `op_start` until a new write.
